// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, IF/ID payload, exception codes.
// Also holds the fetch address legality check used when IF_ADEL_CHECK_EN is defined.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } ifid_t;

    // Unsigned offset from base wraps huge for addresses below base, so one compare covers both ends.
    function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] bytes);
        return (addr[1:0] != 2'b00) || ((addr - base) >= bytes);
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer for an instruction that arrived while decode was stalled.
// load wins over drop; contents are only meaningful while valid=1.
module if_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drop,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        exc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        exc
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            instr <= 32'h0;
            pc    <= 32'h0;
            exc   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
            exc   <= exc_in;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC register, imem request/ack handshake and the IF/ID register.
// Define IF_ADEL_CHECK_EN to squash misaligned/out-of-window fetches into AdEL-tagged bubbles.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_exc
);

`ifdef IF_ADEL_CHECK_EN
    localparam logic ADEL_EN = 1'b1;
`else
    localparam logic ADEL_EN = 1'b0;
`endif

    fetch_state_e state, state_nx;
    logic [31:0]  pc_q, pc_nx, drain_addr;
    ifid_t        ifid_q;

    logic        adel_bad, fetch_ok, fetch_exc;
    logic [31:0] fetch_instr;
    logic        ifid_clr, ifid_ld_fetch, ifid_ld_buf;
    logic        buf_load, buf_drop, drain_ld;
    logic        buf_valid, buf_exc;
    logic [31:0] buf_instr, buf_pc;

    assign adel_bad    = ADEL_EN && fetch_addr_bad(pc_q, IM_BASE, IM_BYTES);
    assign fetch_ok    = adel_bad || imem_ack;
    assign fetch_exc   = adel_bad;
    assign fetch_instr = adel_bad ? NOP_INSTR : imem_rdata;

    always_comb begin
        state_nx      = state;
        pc_nx         = pc_q;
        ifid_clr      = 1'b0;
        ifid_ld_fetch = 1'b0;
        ifid_ld_buf   = 1'b0;
        buf_load      = 1'b0;
        buf_drop      = 1'b0;
        drain_ld      = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = pc_q;

        case (state)
            ST_REQ:   imem_req = !adel_bad;
            ST_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default:  imem_req = 1'b0;
        endcase

        if (flush) begin
            pc_nx    = flush_pc;
            buf_drop = 1'b1;
            ifid_clr = 1'b1;
            // An unacked request must still be retired before the new PC can go out.
            if (imem_req && !imem_ack) begin
                state_nx = ST_DRAIN;
                drain_ld = (state == ST_REQ);
            end else begin
                state_nx = ST_REQ;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (fetch_ok) begin
                        if (stall) begin
                            buf_load = 1'b1;
                            state_nx = ST_HOLD;
                        end else begin
                            ifid_ld_fetch = 1'b1;
                            pc_nx         = npc_in;
                        end
                    end else if (!stall) begin
                        ifid_clr = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_ld_buf = 1'b1;
                        buf_drop    = 1'b1;
                        pc_nx       = npc_in;
                        state_nx    = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) state_nx = ST_REQ;
                end
                default: state_nx = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_REQ;
            pc_q       <= RESET_PC;
            drain_addr <= 32'h0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            if (drain_ld) drain_addr <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_q <= '0;
        end else if (ifid_clr) begin
            ifid_q.valid <= 1'b0;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.exc   <= 1'b0;
        end else if (ifid_ld_fetch) begin
            ifid_q <= '{valid: 1'b1, instr: fetch_instr, pc: pc_q, exc: fetch_exc};
        end else if (ifid_ld_buf) begin
            ifid_q <= '{valid: buf_valid, instr: buf_instr, pc: buf_pc, exc: buf_exc};
        end
    end

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .drop     (buf_drop),
        .instr_in (fetch_instr),
        .pc_in    (pc_q),
        .exc_in   (fetch_exc),
        .valid    (buf_valid),
        .instr    (buf_instr),
        .pc       (buf_pc),
        .exc      (buf_exc)
    );

    assign pc_out      = pc_q;
    assign if_id_valid = ifid_q.valid;
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_exc   = ifid_q.exc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model (pending-entry queue + drain flag).
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc_in;
    logic        stall, flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc;
    logic        if_id_exc;

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .npc_in(npc_in), .stall(stall), .flush(flush),
        .flush_pc(flush_pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc_out(pc_out), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_exc(if_id_exc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus knobs for the next cycle
    logic        s_rst = 1'b0, s_stall = 1'b0, s_flush = 1'b0, s_ack = 1'b0, s_jmp = 1'b0;
    logic [31:0] s_fpc = 32'h0, s_target = 32'h0;

    // model state
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } entry_t;
    entry_t      held[$];
    logic        m_draining;
    logic [31:0] m_drain_addr, m_pc, m_instr, m_ipc;
    logic        m_valid, m_exc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic addr_illegal(input logic [31:0] a);
`ifdef IF_ADEL_CHECK_EN
        return (a[1:0] != 2'b00) || (a < 32'h3000) || (a >= 32'h7000);
`else
        return 1'b0 && (a != a);
`endif
    endfunction

    function automatic logic exp_req();
        if (m_draining) return 1'b1;
        if (held.size() != 0) return 1'b0;
        return !addr_illegal(m_pc);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic   rq;
        entry_t e;
        rq = exp_req();
        if (!s_rst) begin
            held.delete();
            m_draining = 1'b0; m_pc = 32'h3000;
            m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_exc = 1'b0;
        end else if (s_flush) begin
            if (rq && !imem_ack) begin
                if (!m_draining) m_drain_addr = m_pc;
                m_draining = 1'b1;
            end else begin
                m_draining = 1'b0;
            end
            held.delete();
            m_valid = 1'b0; m_instr = 32'h0;
            m_pc = s_fpc;
        end else if (m_draining) begin
            if (imem_ack) m_draining = 1'b0;
        end else if (held.size() != 0) begin
            if (!s_stall) begin
                e = held.pop_front();
                m_valid = 1'b1; m_instr = e.instr; m_ipc = e.pc; m_exc = e.exc;
                m_pc = npc_in;
            end
        end else if (addr_illegal(m_pc) || imem_ack) begin
            e.instr = addr_illegal(m_pc) ? 32'h0 : memf(m_pc);
            e.pc    = m_pc;
            e.exc   = addr_illegal(m_pc);
            if (s_stall) held.push_back(e);
            else begin
                m_valid = 1'b1; m_instr = e.instr; m_ipc = e.pc; m_exc = e.exc;
                m_pc = npc_in;
            end
        end else if (!s_stall) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end
    endtask

    task automatic compare();
        logic rq;
        rq = exp_req();
        chk("pc_out", pc_out, m_pc);
        chk("imem_req", {31'h0, imem_req}, {31'h0, rq});
        if (rq) chk("imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        chk("if_id_instr", if_id_instr, m_valid ? m_instr : 32'h0);
        if (m_valid) begin
            chk("if_id_pc", if_id_pc, m_ipc);
            chk("if_id_exc", {31'h0, if_id_exc}, {31'h0, m_exc});
        end
    endtask

    // Called just after a negedge: drive inputs, advance model, then sample at the next negedge.
    task automatic cycle();
        reset      = s_rst;
        stall      = s_stall;
        flush      = s_flush;
        flush_pc   = s_fpc;
        imem_ack   = s_ack && imem_req;
        imem_rdata = memf(imem_addr);
        npc_in     = s_jmp ? s_target : pc_out + 32'd4;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic set(input logic st, input logic fl, input logic [31:0] fpc, input logic ak);
        s_stall = st; s_flush = fl; s_fpc = fpc; s_ack = ak; s_jmp = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; npc_in = 32'h0;
        m_draining = 1'b0; m_drain_addr = 32'h0; m_pc = 32'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_exc = 1'b0;
        @(negedge clk);

        // 1: reset then zero-wait fetch
        s_rst = 1'b0; set(0, 0, 0, 1);
        cycle(); cycle();
        chk("rst pc_out", pc_out, 32'h3000);
        chk("rst valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst instr", if_id_instr, 32'h0);
        chk("rst if_id_pc", if_id_pc, 32'h0);
        chk("rst exc", {31'h0, if_id_exc}, 32'h0);
        s_rst = 1'b1;
        cycle();
        chk("s1 pc_out", pc_out, 32'h3004);
        chk("s1 if_id_pc", if_id_pc, 32'h3000);
        chk("s1 instr", if_id_instr, memf(32'h3000));
        cycle();
        chk("s1 pc_out2", pc_out, 32'h3008);
        chk("s1 if_id_pc2", if_id_pc, 32'h3004);

        // 2: ack under stall parks the word, release delivers it exactly once
        set(1, 0, 0, 1);
        repeat (3) begin
            cycle();
            chk("s2 req", {31'h0, imem_req}, 32'h0);
            chk("s2 if_id_pc", if_id_pc, 32'h3004);
        end
        set(0, 0, 0, 1);
        cycle();
        chk("s2 if_id_pc rel", if_id_pc, 32'h3008);
        chk("s2 pc_out rel", pc_out, 32'h300C);
        cycle();
        chk("s2 if_id_pc next", if_id_pc, 32'h300C);

        // 3: flush while waiting, late ack is discarded
        set(0, 0, 0, 0);
        cycle();
        set(0, 1, 32'h4180, 0);
        cycle();
        chk("s3 drain addr", imem_addr, 32'h3010);
        chk("s3 drain req", {31'h0, imem_req}, 32'h1);
        chk("s3 valid", {31'h0, if_id_valid}, 32'h0);
        set(0, 0, 0, 1);
        cycle();
        chk("s3 new addr", imem_addr, 32'h4180);
        chk("s3 valid2", {31'h0, if_id_valid}, 32'h0);
        cycle();
        chk("s3 if_id_pc", if_id_pc, 32'h4180);

        // 4: flush + stall in HOLD
        set(1, 0, 0, 1);
        cycle();
        set(1, 1, 32'h5000, 0);
        cycle();
        chk("s4 pc_out", pc_out, 32'h5000);
        chk("s4 valid", {31'h0, if_id_valid}, 32'h0);
        set(0, 0, 0, 1);
        cycle();
        chk("s4 if_id_pc", if_id_pc, 32'h5000);

        // 5: illegal fetch targets
        s_jmp = 1'b1; s_target = 32'h3002;
        cycle();
        chk("s5 pc", pc_out, 32'h3002);
        s_target = 32'h7000;
        cycle();
`ifdef IF_ADEL_CHECK_EN
        chk("s5 exc", {31'h0, if_id_exc}, 32'h1);
        chk("s5 instr", if_id_instr, 32'h0);
        chk("s5 if_id_pc", if_id_pc, 32'h3002);
        chk("s5 req 7000", {31'h0, imem_req}, 32'h0);
`else
        chk("s5 instr", if_id_instr, memf(32'h3002));
        chk("s5 req 7000", {31'h0, imem_req}, 32'h1);
        chk("s5 addr 7000", imem_addr, 32'h7000);
`endif
        s_target = 32'h3000;
        cycle();
        chk("s5 if_id_pc2", if_id_pc, 32'h7000);
        s_jmp = 1'b0;

        // 6: reset while draining
        set(0, 1, 32'h3100, 0);
        cycle();
        set(0, 0, 0, 0);
        s_rst = 1'b0;
        cycle();
        chk("s6 pc_out", pc_out, 32'h3000);
        chk("s6 valid", {31'h0, if_id_valid}, 32'h0);
        chk("s6 addr", imem_addr, 32'h3000);
        s_rst = 1'b1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            s_rst   = ($urandom % 600) != 0;
            s_ack   = ($urandom % 3) != 0;
            s_stall = ($urandom % 4) == 0;
            s_flush = ($urandom % 14) == 0;
            // flush coinciding with the draining request's own ack is left out of the traffic
            if (m_draining && s_ack) s_flush = 1'b0;
            s_fpc   = 32'h3000 + ($urandom % 32'h4000 & 32'hFFFF_FFFC);
            s_jmp   = ($urandom % 6) == 0;
            case ($urandom % 12)
                0:       s_target = 32'h7000 + ($urandom % 64) * 4;
                1:       s_target = 32'h3002 + ($urandom % 64) * 4;
                default: s_target = 32'h3000 + ($urandom % 32'h4000 & 32'hFFFF_FFFC);
            endcase
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
